// File: rtl/mio_pkg.sv
// Shared types for the memory/IO bus arbiter: FSM state encoding and owner codes.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  // Wide enough for MEM_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mio_arb_pick.sv
// Combinational winner select between CPU and DMA requests.
// Optional feature macro: MIO_ARB_RR_EN (round-robin on contention; default is fixed CPU priority).
module mio_arb_pick
  import mio_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dma_req,
`ifdef MIO_ARB_RR_EN
  input  logic       last_dma,
`endif
  output logic [1:0] winner
);

  always_comb begin
    winner = OWN_NONE;
    if (cpu_req && dma_req) begin
`ifdef MIO_ARB_RR_EN
      winner = last_dma ? OWN_CPU : OWN_DMA;
`else
      winner = OWN_CPU;
`endif
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Single-port memory/IO bus arbiter between the CPU controller and a DMA master.
// Optional feature macro: MIO_ARB_RR_EN selects round-robin arbitration instead of fixed CPU priority.
//
// Handshake: a master holds req (with we/addr/wdata) until its one-cycle ready pulse;
// request fields are latched at grant and ignored afterwards, and read data is valid
// in the rdata register from the ready cycle until that master's next read completes.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output state_t            state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             pick_dma;

`ifdef MIO_ARB_RR_EN
  logic last_dma;
`endif

  mio_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
`ifdef MIO_ARB_RR_EN
    .last_dma (last_dma),
`endif
    .winner   (pick)
  );

  assign pick_dma  = (pick == OWN_DMA);
  assign state_dbg = state;

  // The mem_* registers double as the latched request; owner names the winner until DONE ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWN_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
`ifdef MIO_ARB_RR_EN
      last_dma  <= 1'b1;
`endif
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != OWN_NONE) begin
            state     <= ACCESS;
            owner     <= pick;
            cnt       <= CNT_LOAD;
            mem_en    <= 1'b1;
            mem_we    <= pick_dma ? dma_we    : cpu_we;
            mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
`ifdef MIO_ARB_RR_EN
            last_dma  <= pick_dma;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWN_DMA) begin
              dma_ready <= 1'b1;
              if (!mem_we) dma_rdata <= mem_rdata;
            end else begin
              cpu_ready <= 1'b1;
              if (!mem_we) cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) driven by directed scenarios
// and a randomized run checked against a cycle-arithmetic transaction model.
module tb_mio_arbiter;
  import mio_pkg::*;

`ifdef MIO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // index 0: MEM_LAT=1 instance, index 1: MEM_LAT=3 instance
  logic        cpu_req [2], cpu_we [2], dma_req [2], dma_we [2];
  logic [31:0] cpu_addr [2], cpu_wdata [2], dma_addr [2], dma_wdata [2];
  logic [31:0] cpu_rdata [2], dma_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic        cpu_ready [2], dma_ready [2], mem_en [2], mem_we [2];
  logic [1:0]  owner [2];
  state_t      state_dbg [2];

  logic [31:0] exp_cpu_rd [2];
  logic [31:0] exp_dma_rd [2];
  int n_checks = 0;
  int n_pass   = 0;

  mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ready(cpu_ready[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
    .dma_rdata(dma_rdata[0]), .dma_ready(dma_ready[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .owner(owner[0]), .state_dbg(state_dbg[0])
  );

  mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ready(cpu_ready[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
    .dma_rdata(dma_rdata[1]), .dma_ready(dma_ready[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .owner(owner[1]), .state_dbg(state_dbg[1])
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  assign mem_rdata[0] = mem_model(mem_addr[0]);
  assign mem_rdata[1] = mem_model(mem_addr[1]);

  // ---------------- driver tasks ----------------
  task automatic clear_inputs(input int k);
    cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
    dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = '0; dma_wdata[k] = '0;
  endtask

  task automatic drive_req(input int k, input bit dma, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (dma) begin
      dma_req[k] = req; dma_we[k] = we; dma_addr[k] = addr; dma_wdata[k] = wdata;
    end else begin
      cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
    end
  endtask

  // Leaves the bench at posedge+1 with both instances idle and rdata expectations cleared.
  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs(0);
    clear_inputs(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_cpu_rd[k] = '0;
      exp_dma_rd[k] = '0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs(0);
    clear_inputs(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (mem_en[k] !== 1'b0) $display("FAIL reset.mem_en k=%0d got %b want 0", k, mem_en[k]); else n_pass++;
      n_checks++; if (mem_we[k] !== 1'b0) $display("FAIL reset.mem_we k=%0d got %b want 0", k, mem_we[k]); else n_pass++;
      n_checks++; if (owner[k] !== OWN_NONE) $display("FAIL reset.owner k=%0d got %b want 00", k, owner[k]); else n_pass++;
      n_checks++; if ({cpu_ready[k], dma_ready[k]} !== 2'b00) $display("FAIL reset.ready k=%0d got %b%b want 00", k, cpu_ready[k], dma_ready[k]); else n_pass++;
      n_checks++; if ({cpu_rdata[k], dma_rdata[k]} !== 64'd0) $display("FAIL reset.rdata k=%0d got %h/%h want 0", k, cpu_rdata[k], dma_rdata[k]); else n_pass++;
      n_checks++; if ({mem_addr[k], mem_wdata[k]} !== 64'd0) $display("FAIL reset.mem_bus k=%0d got %h/%h want 0", k, mem_addr[k], mem_wdata[k]); else n_pass++;
      n_checks++; if (state_dbg[k] !== IDLE) $display("FAIL reset.state k=%0d got %0d want IDLE", k, state_dbg[k]); else n_pass++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_cpu_rd[k] = '0;
      exp_dma_rd[k] = '0;
    end
  endtask

  // One access on instance k; cycle c=0 is the IDLE cycle in which req is first seen.
  task automatic test_single(input int k, input bit dma, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit drop_early);
    int         lat;
    logic [1:0] win;
    logic       exp_en, exp_rdy;
    logic [1:0] exp_own;
    lat = (k == 0) ? 1 : 3;
    win = dma ? OWN_DMA : OWN_CPU;
    for (int c = 0; c <= lat + 2; c++) begin
      if (c == 0) drive_req(k, dma, 1'b1, we, addr, wdata);
      if (drop_early && c == 1) drive_req(k, dma, 1'b0, ~we, ~addr, ~wdata);
      if (!drop_early && c == lat + 1) drive_req(k, dma, 1'b0, we, addr, wdata);
      @(negedge clk);
      exp_en  = (c >= 1 && c <= lat);
      exp_rdy = (c == lat + 1);
      exp_own = (c >= 1 && c <= lat + 1) ? win : OWN_NONE;
      if (exp_rdy && !we) begin
        if (dma) exp_dma_rd[k] = mem_model(addr);
        else     exp_cpu_rd[k] = mem_model(addr);
      end
      n_checks++; if (mem_en[k] !== exp_en) $display("FAIL single.mem_en k=%0d c=%0d got %b want %b", k, c, mem_en[k], exp_en); else n_pass++;
      n_checks++; if (owner[k] !== exp_own) $display("FAIL single.owner k=%0d c=%0d got %b want %b", k, c, owner[k], exp_own); else n_pass++;
      n_checks++; if (cpu_ready[k] !== (exp_rdy && !dma)) $display("FAIL single.cpu_ready k=%0d c=%0d got %b want %b", k, c, cpu_ready[k], exp_rdy && !dma); else n_pass++;
      n_checks++; if (dma_ready[k] !== (exp_rdy && dma)) $display("FAIL single.dma_ready k=%0d c=%0d got %b want %b", k, c, dma_ready[k], exp_rdy && dma); else n_pass++;
      n_checks++; if (cpu_rdata[k] !== exp_cpu_rd[k]) $display("FAIL single.cpu_rdata k=%0d c=%0d got %h want %h", k, c, cpu_rdata[k], exp_cpu_rd[k]); else n_pass++;
      n_checks++; if (dma_rdata[k] !== exp_dma_rd[k]) $display("FAIL single.dma_rdata k=%0d c=%0d got %h want %h", k, c, dma_rdata[k], exp_dma_rd[k]); else n_pass++;
      if (exp_en) begin
        n_checks++; if (mem_we[k] !== we) $display("FAIL single.mem_we k=%0d c=%0d got %b want %b", k, c, mem_we[k], we); else n_pass++;
        n_checks++; if (mem_addr[k] !== addr) $display("FAIL single.mem_addr k=%0d c=%0d got %h want %h", k, c, mem_addr[k], addr); else n_pass++;
        n_checks++; if (mem_wdata[k] !== wdata) $display("FAIL single.mem_wdata k=%0d c=%0d got %h want %h", k, c, mem_wdata[k], wdata); else n_pass++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Both masters request continuously for four accesses on the MEM_LAT=1 instance.
  task automatic test_priority();
    logic [1:0] exp_q[$];
    logic [1:0] w, prev;
    bit         last_dma;
    apply_reset();
    last_dma = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (RR) w = last_dma ? OWN_CPU : OWN_DMA;
      else    w = OWN_CPU;
      exp_q.push_back(w);
      last_dma = (w == OWN_DMA);
    end
    prev = OWN_NONE;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) begin
        drive_req(0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hC0C0_0001);
        drive_req(0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hD0D0_0002);
      end
      if (c == 12) clear_inputs(0);
      @(negedge clk);
      if (owner[0] !== OWN_NONE && prev === OWN_NONE) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL priority.extra_grant c=%0d got %b want none", c, owner[0]);
        else begin
          w = exp_q.pop_front();
          if (owner[0] !== w) $display("FAIL priority.winner c=%0d got %b want %b", c, owner[0], w); else n_pass++;
        end
      end
      prev = owner[0];
      @(posedge clk);
      #1;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL priority.missing_grants got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_drop_req();
    test_single(0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b1);
    test_single(1, 1'b1, 1'b0, 32'h0000_0A40, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive_req(1, 1'b0, 1'b1, 1'b0, 32'h0000_0088, 32'h0);
    @(negedge clk);
    n_checks++; if (owner[1] !== OWN_NONE) $display("FAIL reset_mid.owner_t0 got %b want 00", owner[1]); else n_pass++;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++; if (mem_en[1] !== 1'b1) $display("FAIL reset_mid.mem_en_before got %b want 1", mem_en[1]); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_en[1] !== 1'b0) $display("FAIL reset_mid.mem_en got %b want 0", mem_en[1]); else n_pass++;
    n_checks++; if (owner[1] !== OWN_NONE) $display("FAIL reset_mid.owner got %b want 00", owner[1]); else n_pass++;
    n_checks++; if ({cpu_ready[1], dma_ready[1]} !== 2'b00) $display("FAIL reset_mid.ready got %b%b want 00", cpu_ready[1], dma_ready[1]); else n_pass++;
    n_checks++; if (state_dbg[1] !== IDLE) $display("FAIL reset_mid.state got %0d want IDLE", state_dbg[1]); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      exp_cpu_rd[k] = '0;
      exp_dma_rd[k] = '0;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    // req is still pending: this cycle is a fresh IDLE cycle
    test_single(1, 1'b0, 1'b0, 32'h0000_0088, 32'h0, 1'b0);
  endtask

  // CPU keeps req high through the IDLE cycle after ready: exactly one new access, no duplicate ready.
  task automatic test_back_to_back();
    int          lat, n_rdy;
    logic        exp_en, exp_rdy;
    logic [1:0]  exp_own;
    logic [31:0] a_exp;
    lat   = 1;
    n_rdy = 0;
    for (int c = 0; c <= 2 * lat + 4; c++) begin
      if (c == 0) drive_req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
      if (c == lat + 2) drive_req(0, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
      if (c == lat + 3) drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_0F00, 32'h0);
      @(negedge clk);
      exp_en  = (c >= 1 && c <= lat) || (c >= lat + 3 && c <= 2 * lat + 2);
      exp_rdy = (c == lat + 1) || (c == 2 * lat + 3);
      exp_own = ((c >= 1 && c <= lat + 1) || (c >= lat + 3 && c <= 2 * lat + 3)) ? OWN_CPU : OWN_NONE;
      a_exp   = (c <= lat + 1) ? 32'h0000_0030 : 32'h0000_0044;
      if (exp_rdy) exp_cpu_rd[0] = mem_model(a_exp);
      if (cpu_ready[0] === 1'b1) n_rdy++;
      n_checks++; if (mem_en[0] !== exp_en) $display("FAIL b2b.mem_en c=%0d got %b want %b", c, mem_en[0], exp_en); else n_pass++;
      n_checks++; if (cpu_ready[0] !== exp_rdy) $display("FAIL b2b.cpu_ready c=%0d got %b want %b", c, cpu_ready[0], exp_rdy); else n_pass++;
      n_checks++; if (owner[0] !== exp_own) $display("FAIL b2b.owner c=%0d got %b want %b", c, owner[0], exp_own); else n_pass++;
      n_checks++; if (cpu_rdata[0] !== exp_cpu_rd[0]) $display("FAIL b2b.cpu_rdata c=%0d got %h want %h", c, cpu_rdata[0], exp_cpu_rd[0]); else n_pass++;
      if (exp_en) begin
        n_checks++; if (mem_addr[0] !== a_exp) $display("FAIL b2b.mem_addr c=%0d got %h want %h", c, mem_addr[0], a_exp); else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    n_checks++; if (n_rdy != 2) $display("FAIL b2b.ready_count got %0d want 2", n_rdy); else n_pass++;
  endtask

  // Random traffic: each master raises a request at random and holds it until its ready pulse.
  // The model grants at the end of any cycle in which the bus is free, then predicts the
  // mem_en window, owner span and ready cycle from the grant cycle by arithmetic.
  task automatic test_random(input int k, input int n_cyc);
    int          lat, g_at, idle_at, wm;
    bit          act [2];
    logic        r_we [2];
    logic [31:0] r_addr [2], r_wdata [2];
    bit          have_win, last_dma;
    logic        g_we;
    logic [31:0] g_addr, g_wdata;
    logic        exp_en, exp_rdy;
    logic [1:0]  exp_own, win_code;
    apply_reset();
    lat      = (k == 0) ? 1 : 3;
    g_at     = -100;
    idle_at  = 0;
    wm       = 0;
    have_win = 1'b0;
    last_dma = 1'b1;
    g_we     = 1'b0;
    g_addr   = '0;
    g_wdata  = '0;
    act[0]   = 1'b0;
    act[1]   = 1'b0;
    for (int cyc = 0; cyc < n_cyc; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && cyc < n_cyc - 16 && $urandom_range(0, 2) == 0) begin
          act[m]     = 1'b1;
          r_we[m]    = 1'($urandom_range(0, 1));
          r_addr[m]  = $urandom & 32'hFFFF_FFFC;
          r_wdata[m] = $urandom;
          drive_req(k, m == 1, 1'b1, r_we[m], r_addr[m], r_wdata[m]);
        end
      end
      @(negedge clk);
      win_code = (wm == 1) ? OWN_DMA : OWN_CPU;
      exp_en   = have_win && cyc >= g_at + 1 && cyc <= g_at + lat;
      exp_rdy  = have_win && cyc == g_at + lat + 1;
      exp_own  = (have_win && cyc >= g_at + 1 && cyc <= g_at + lat + 1) ? win_code : OWN_NONE;
      if (exp_rdy && !g_we) begin
        if (wm == 1) exp_dma_rd[k] = mem_model(g_addr);
        else         exp_cpu_rd[k] = mem_model(g_addr);
      end
      n_checks++; if (mem_en[k] !== exp_en) $display("FAIL rand.mem_en k=%0d cyc=%0d got %b want %b", k, cyc, mem_en[k], exp_en); else n_pass++;
      n_checks++; if (owner[k] !== exp_own) $display("FAIL rand.owner k=%0d cyc=%0d got %b want %b", k, cyc, owner[k], exp_own); else n_pass++;
      n_checks++; if (cpu_ready[k] !== (exp_rdy && wm == 0)) $display("FAIL rand.cpu_ready k=%0d cyc=%0d got %b want %b", k, cyc, cpu_ready[k], exp_rdy && wm == 0); else n_pass++;
      n_checks++; if (dma_ready[k] !== (exp_rdy && wm == 1)) $display("FAIL rand.dma_ready k=%0d cyc=%0d got %b want %b", k, cyc, dma_ready[k], exp_rdy && wm == 1); else n_pass++;
      n_checks++; if (cpu_rdata[k] !== exp_cpu_rd[k]) $display("FAIL rand.cpu_rdata k=%0d cyc=%0d got %h want %h", k, cyc, cpu_rdata[k], exp_cpu_rd[k]); else n_pass++;
      n_checks++; if (dma_rdata[k] !== exp_dma_rd[k]) $display("FAIL rand.dma_rdata k=%0d cyc=%0d got %h want %h", k, cyc, dma_rdata[k], exp_dma_rd[k]); else n_pass++;
      if (exp_en) begin
        n_checks++; if ({mem_we[k], mem_addr[k], mem_wdata[k]} !== {g_we, g_addr, g_wdata})
          $display("FAIL rand.mem_bus k=%0d cyc=%0d got %b/%h/%h want %b/%h/%h", k, cyc, mem_we[k], mem_addr[k], mem_wdata[k], g_we, g_addr, g_wdata);
        else n_pass++;
      end
      if (exp_rdy) begin
        act[wm] = 1'b0;
        drive_req(k, wm == 1, 1'b0, 1'b0, '0, '0);
      end
      if (cyc >= idle_at && (act[0] || act[1])) begin
        if (act[0] && act[1]) wm = (RR && !last_dma) ? 1 : 0;
        else                  wm = act[0] ? 0 : 1;
        last_dma = (wm == 1);
        have_win = 1'b1;
        g_at     = cyc;
        idle_at  = cyc + lat + 2;
        g_we     = r_we[wm];
        g_addr   = r_addr[wm];
        g_wdata  = r_wdata[wm];
      end
      @(posedge clk);
      #1;
    end
    n_checks++; if (act[0] || act[1]) $display("FAIL rand.unserved k=%0d got %b%b want 00", k, act[0], act[1]); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    clear_inputs(0);
    clear_inputs(1);
    test_reset();
    test_single(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    test_single(1, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0);
    test_priority();
    test_drop_req();
    test_reset_mid();
    test_back_to_back();
    test_random(0, 300);
    test_random(1, 300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
